// File: rtl/boom_mem_arb_pkg.sv
// Shared types and helpers for the BOOM memory-port arbiter.
// mem_req_t is sized for the widest supported memory; narrower instances use its low bits.
package boom_mem_arb_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/boom_rr_arbiter.sv
// Round-robin arbiter with bounded burst hold: the last winner keeps the grant
// for up to MAX_BURST consecutive cycles while others wait, unlimited when alone.
module boom_rr_arbiter
    import boom_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);
    localparam int IW = idx_w(NUM_PORTS);
    localparam int CW = idx_w(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    logic [IW-1:0]        ptr, last, win;
    logic [CW-1:0]        cnt;
    logic                 last_vld, fresh, found;
    logic [NUM_PORTS-1:0] last_oh;
    int                   cand;

    always_comb begin
        gnt     = '0;
        win     = last;
        fresh   = 1'b0;
        found   = 1'b0;
        cand    = 0;
        last_oh = '0;
        last_oh[last] = 1'b1;
        if (last_vld && req[last] && (cnt < CNT_MAX || (req & ~last_oh) == '0)) begin
            gnt = last_oh;
        end else begin
            // Search starts at ptr, which sits just past the previous winner, so a
            // forced-off winner is reached last.
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = (int'(ptr) + k) % NUM_PORTS;
                if (!found && req[IW'(cand)]) begin
                    found = 1'b1;
                    win   = IW'(cand);
                end
            end
            if (found) begin
                gnt[win] = 1'b1;
                fresh    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            last     <= '0;
            last_vld <= 1'b0;
        end else if (|gnt) begin
            last_vld <= 1'b1;
            last     <= win;
            if (fresh) begin
                cnt <= '0;
                ptr <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            last_vld <= 1'b0;
        end
    end
endmodule

// File: rtl/boom_mem_port_arbiter.sv
// Shares one single-port memory between NUM_PORTS requesters; each accepted
// request gets exactly one response on its own port the following cycle.
module boom_mem_port_arbiter
    import boom_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int MAX_BURST  = 4
) (
    input  logic                              clock,
    input  logic                              reset_wire_reset,
    input  logic [NUM_PORTS-1:0]              p_req_i,
    output logic [NUM_PORTS-1:0]              p_gnt_o,
    input  logic [NUM_PORTS-1:0]              p_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] p_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_wdata_i,
    output logic [NUM_PORTS-1:0]              p_rvalid_o,
    output logic [DATA_WIDTH-1:0]             p_rdata_o,
    output logic                              req_o,
    output logic                              we_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic [DATA_WIDTH/8-1:0]           be_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    input  logic [DATA_WIDTH-1:0]             data_i
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IW   = idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] gnt, gnt_g;
    mem_req_t             sel;
    logic [IW-1:0]        sel_idx, rsp_port;
    logic                 rsp_valid;

    boom_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk (clock),
        .rst (reset_wire_reset),
        .req (p_req_i),
        .gnt (gnt)
    );

    assign gnt_g   = reset_wire_reset ? '0 : gnt;
    assign p_gnt_o = gnt_g;
    assign req_o   = |(p_req_i & gnt_g);

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_g[p]) begin
                sel.we                    = p_we_i[p];
                sel.addr[ADDR_WIDTH-1:0]  = p_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel.be[BE_W-1:0]          = p_be_i[p*BE_W +: BE_W];
                sel.wdata[DATA_WIDTH-1:0] = p_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                sel_idx                   = IW'(p);
            end
        end
    end

    assign we_o   = sel.we;
    assign addr_o = sel.addr[ADDR_WIDTH-1:0];
    assign be_o   = sel.be[BE_W-1:0];
    assign data_o = sel.wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset_wire_reset) begin
        if (reset_wire_reset) begin
            rsp_valid <= 1'b0;
            rsp_port  <= '0;
        end else begin
            rsp_valid <= req_o;
            if (req_o) rsp_port <= sel_idx;
        end
    end

    // Read data is not registered here: the memory already delivers it one cycle late.
    always_comb begin
        p_rvalid_o = '0;
        p_rdata_o  = '0;
        if (rsp_valid && !reset_wire_reset) begin
            p_rvalid_o[rsp_port] = 1'b1;
            p_rdata_o            = data_i;
        end
    end

    a_gnt_onehot: assert property (@(posedge clock) disable iff (reset_wire_reset)
        $onehot0(p_gnt_o));
    a_gnt_req: assert property (@(posedge clock) disable iff (reset_wire_reset)
        (p_gnt_o & ~p_req_i) == '0);
    a_rvalid: assert property (@(posedge clock) disable iff (reset_wire_reset)
        (|p_rvalid_o) |-> $past(req_o));
endmodule
